// File: rtl/mem_arbiter_if.sv
// Requester/RAM bus bundle for mem_arbiter: master is the arbiter side, slave the
// requesters plus RAM. Requester i owns bits [i] and [i*AW +: AW] of the vectors.
interface mem_arbiter_if #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AW   = 32
);
  logic [NREQ-1:0]    req_ren;
  logic [NREQ-1:0]    req_wen;
  logic [NREQ-1:0]    req_ll;
  logic [NREQ-1:0]    req_sc;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*AW-1:0] req_store;
  logic [NREQ-1:0]    req_ack;
  logic [AW-1:0]      req_load;
  logic               sc_ok;
  logic               ramREN;
  logic               ramWEN;
  logic [AW-1:0]      ramaddr;
  logic [AW-1:0]      ramstore;
  logic [AW-1:0]      ramload;
  logic               ram_ready;

  modport master (
    input  req_ren, req_wen, req_ll, req_sc, req_addr, req_store, ramload, ram_ready,
    output req_ack, req_load, sc_ok, ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    output req_ren, req_wen, req_ll, req_sc, req_addr, req_store, ramload, ram_ready,
    input  req_ack, req_load, sc_ok, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one RAM port among NREQ requesters.
// Define ATOMIC_RSV_EN to add per-requester LL/SC link registers.
module mem_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AW   = 32
) (
  input logic           CLK,
  input logic           nRST,
  mem_arbiter_if.master bus
);
  localparam int unsigned GW = $clog2(NREQ);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t          r_state, w_state_nxt;
  logic [GW-1:0]   r_gnt, w_gnt_nxt;
  logic [GW-1:0]   r_rr_ptr, w_rr_nxt;
  logic [GW-1:0]   w_sel, w_idx;
  logic            w_sel_found;
  logic [NREQ-1:0] w_req_pend;
  logic            w_ren, w_wen, w_pend;
  logic [AW-1:0]   w_addr, w_store;
  logic            w_done;
  logic            w_sc_fail;
  logic            w_sc_ok_done;

  assign w_req_pend = bus.req_ren | bus.req_wen;
  assign w_ren      = bus.req_ren[r_gnt];
  assign w_wen      = bus.req_wen[r_gnt];
  assign w_pend     = w_ren | w_wen;
  assign w_addr     = bus.req_addr[32'(r_gnt)*AW +: AW];
  assign w_store    = bus.req_store[32'(r_gnt)*AW +: AW];

  // Scan downward so the nearest pending index at or after rr_ptr is the last write.
  always_comb begin
    w_sel       = '0;
    w_idx       = '0;
    w_sel_found = 1'b0;
    for (int unsigned k = NREQ; k > 0; k--) begin
      w_idx = GW'((32'(r_rr_ptr) + k - 1) % NREQ);
      if (w_req_pend[w_idx]) begin
        w_sel       = w_idx;
        w_sel_found = 1'b1;
      end
    end
  end

`ifdef ATOMIC_RSV_EN
  logic [NREQ-1:0] r_link_v;
  logic [AW-1:0]   r_link_a [NREQ];
  logic            w_is_sc;

  assign w_is_sc      = w_wen & bus.req_sc[r_gnt];
  assign w_sc_fail    = w_is_sc & ~(r_link_v[r_gnt] && (r_link_a[r_gnt] == w_addr));
  assign w_sc_ok_done = w_is_sc;

  // Any completed write (including a passing SC) kills every link on that address.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_link_v <= '0;
      for (int unsigned i = 0; i < NREQ; i++) r_link_a[i] <= '0;
    end else if (w_done && !w_sc_fail) begin
      if (w_wen) begin
        for (int unsigned i = 0; i < NREQ; i++)
          if (r_link_a[i] == w_addr) r_link_v[i] <= 1'b0;
      end else if (bus.req_ll[r_gnt]) begin
        r_link_v[r_gnt] <= 1'b1;
        r_link_a[r_gnt] <= w_addr;
      end
    end
  end
`else
  logic w_unused_rsv;

  assign w_unused_rsv = ^{bus.req_ll, bus.req_sc};
  assign w_sc_fail    = 1'b0;
  assign w_sc_ok_done = 1'b1;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_rr_ptr <= w_rr_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = r_gnt;
    w_rr_nxt     = r_rr_ptr;
    w_done       = 1'b0;
    bus.req_ack  = '0;
    bus.req_load = '0;
    bus.sc_ok    = 1'b0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    unique case (r_state)
      IDLE: begin
        if (w_sel_found) begin
          w_gnt_nxt   = w_sel;
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (!w_pend) begin
          w_state_nxt = IDLE;
        end else if (w_sc_fail) begin
          w_done = 1'b1;
        end else begin
          bus.ramWEN   = w_wen;
          bus.ramREN   = w_ren & ~w_wen;
          bus.ramaddr  = w_addr;
          bus.ramstore = w_store;
          if (bus.ram_ready) begin
            w_done       = 1'b1;
            bus.req_load = bus.ramload;
            bus.sc_ok    = w_sc_ok_done;
          end
        end
        if (w_done) begin
          bus.req_ack = NREQ'(1) << r_gnt;
          w_rr_nxt    = (r_gnt == GW'(NREQ - 1)) ? '0 : r_gnt + 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end
endmodule
